alu_exec_stage: RTL and testbench

//  Registered execute stage for the single-cycle MIPS-style datapath.
//  - Merges ALU-control decode (ALUOp + funct -> 4-bit select), the 32-bit ALU with zero flag, and the PC+4 / branch-target adders.
//  - Outputs are captured on clk, so downstream blocks (data memory, write-back mux, PC mux) see stable values.

---
 rtl/alu_exec_stage_if.sv | 34 +++
 rtl/alu_exec_stage.sv | 135 +++++++++++++
 tb/tb_alu_exec_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_if.sv
// Execute-stage bus bundle: operand, control and result signals.
//  master : the side that drives pc/operands/control and consumes results
//  slave  : the execute stage itself (alu_exec_stage)
//  Inputs to the stage: pc, read_data1, read_data2, ext_offset, alu_src,
//                       alu_op, funct, branch
//  Outputs of the stage: alu_sel (combinational), alu_result, zf, pc_plus4,
//                        branch_target, take_branch, ovf (all registered)
interface alu_exec_stage_if;
  logic [31:0] pc;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] ext_offset;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic        branch;
  logic [3:0]  alu_sel;
  logic [31:0] alu_result;
  logic        zf;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        take_branch;
  logic        ovf;

  modport master (
    output pc, read_data1, read_data2, ext_offset, alu_src, alu_op, funct, branch,
    input  alu_sel, alu_result, zf, pc_plus4, branch_target, take_branch, ovf
  );

  modport slave (
    input  pc, read_data1, read_data2, ext_offset, alu_src, alu_op, funct, branch,
    output alu_sel, alu_result, zf, pc_plus4, branch_target, take_branch, ovf
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered execute stage of a single-cycle MIPS-style datapath.
// Combines ALU-control decode (alu_op + funct -> 4-bit select), a 32-bit ALU
// with zero flag, and the pc+4 / branch-target adders. All results are
// captured on the rising clock edge (1-cycle latency); only alu_sel is
// combinational.
// Ports:
//  clk  - system clock, rising edge
//  rst  - asynchronous active-high reset, clears all registered outputs
//  bus  - alu_exec_stage_if.slave (operands/control in, results out)
// Optional feature: define ALU_OVF_EN to generate the signed-overflow flag
// for ADD/SUB; otherwise ovf is tied to 0.
module alu_exec_stage (
  input  logic              clk,
  input  logic              rst,
  alu_exec_stage_if.slave   bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  localparam logic [SEL_W-1:0] SEL_AND = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_OR  = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_ADD = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_XOR = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_SUB = 4'b0110;
  localparam logic [SEL_W-1:0] SEL_SLT = 4'b0111;
  localparam logic [SEL_W-1:0] SEL_NOR = 4'b1100;
  localparam logic [SEL_W-1:0] SEL_BAD = 4'b1111;

  logic [SEL_W-1:0]  alu_sel_c;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  logic [DATA_W-1:0] alu_result_d,    alu_result_q;
  logic              zf_d,            zf_q;
  logic [DATA_W-1:0] pc_plus4_d,      pc_plus4_q;
  logic [DATA_W-1:0] branch_target_d, branch_target_q;
  logic              take_branch_d,   take_branch_q;

  // ALU-control decode: alu_op selects directly, or defers to funct for R-type
  always_comb begin
    alu_sel_c = SEL_BAD;
    unique case (bus.alu_op)
      3'b000: alu_sel_c = SEL_ADD;
      3'b001: alu_sel_c = SEL_SUB;
      3'b010: begin
        unique case (bus.funct)
          6'b100000: alu_sel_c = SEL_ADD;
          6'b100010: alu_sel_c = SEL_SUB;
          6'b100100: alu_sel_c = SEL_AND;
          6'b100101: alu_sel_c = SEL_OR;
          6'b100110: alu_sel_c = SEL_XOR;
          6'b100111: alu_sel_c = SEL_NOR;
          6'b101010: alu_sel_c = SEL_SLT;
          default:   alu_sel_c = SEL_BAD;
        endcase
      end
      3'b011: alu_sel_c = SEL_AND;
      3'b100: alu_sel_c = SEL_OR;
      3'b101: alu_sel_c = SEL_SLT;
      3'b110: alu_sel_c = SEL_XOR;
      3'b111: alu_sel_c = SEL_NOR;
      default: alu_sel_c = SEL_BAD;
    endcase
  end

  assign bus.alu_sel = alu_sel_c;
  assign op1 = bus.read_data1;
  assign op2 = bus.alu_src ? bus.ext_offset : bus.read_data2;

  // ALU, zero flag and PC adders; zf/take_branch use the result being registered
  always_comb begin
    alu_result_d = '0;
    unique case (alu_sel_c)
      SEL_ADD: alu_result_d = op1 + op2;
      SEL_SUB: alu_result_d = op1 - op2;
      SEL_AND: alu_result_d = op1 & op2;
      SEL_OR:  alu_result_d = op1 | op2;
      SEL_XOR: alu_result_d = op1 ^ op2;
      SEL_NOR: alu_result_d = ~(op1 | op2);
      SEL_SLT: alu_result_d = DATA_W'(($signed(op1) < $signed(op2)) ? 1 : 0);
      default: alu_result_d = '0;
    endcase
    zf_d            = (alu_result_d == '0);
    take_branch_d   = bus.branch & zf_d;
    pc_plus4_d      = bus.pc + DATA_W'(4);
    branch_target_d = pc_plus4_d + {bus.ext_offset[DATA_W-3:0], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_q    <= '0;
      zf_q            <= 1'b0;
      pc_plus4_q      <= '0;
      branch_target_q <= '0;
      take_branch_q   <= 1'b0;
    end else begin
      alu_result_q    <= alu_result_d;
      zf_q            <= zf_d;
      pc_plus4_q      <= pc_plus4_d;
      branch_target_q <= branch_target_d;
      take_branch_q   <= take_branch_d;
    end
  end

  assign bus.alu_result    = alu_result_q;
  assign bus.zf            = zf_q;
  assign bus.pc_plus4      = pc_plus4_q;
  assign bus.branch_target = branch_target_q;
  assign bus.take_branch   = take_branch_q;

`ifdef ALU_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: ADD when operand signs match and result sign flips;
  // SUB when operand signs differ and result sign differs from op1.
  always_comb begin
    ovf_d = 1'b0;
    if (alu_sel_c == SEL_ADD)
      ovf_d = (op1[DATA_W-1] == op2[DATA_W-1]) && (alu_result_d[DATA_W-1] != op1[DATA_W-1]);
    else if (alu_sel_c == SEL_SUB)
      ovf_d = (op1[DATA_W-1] != op2[DATA_W-1]) && (alu_result_d[DATA_W-1] != op1[DATA_W-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage: hand-computed vectors for decode,
// ALU ops, zero flag, branch logic, PC adders, overflow and async reset.
module tb_alu_exec_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

`ifdef ALU_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  alu_exec_stage_if bus_i ();

  alu_exec_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a vector at negedge, check the combinational select, then clock it in.
  task automatic run(input logic [31:0] pc, input logic [31:0] rd1, input logic [31:0] rd2,
                     input logic [31:0] ext, input logic src, input logic [2:0] op,
                     input logic [5:0] fn, input logic br, input string tag,
                     input logic [3:0] exp_sel);
    @(negedge clk);
    bus_i.pc         = pc;
    bus_i.read_data1 = rd1;
    bus_i.read_data2 = rd2;
    bus_i.ext_offset = ext;
    bus_i.alu_src    = src;
    bus_i.alu_op     = op;
    bus_i.funct      = fn;
    bus_i.branch     = br;
    #1;
    chk({tag, "_sel"}, 32'(bus_i.alu_sel), 32'(exp_sel));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_i.pc = '0; bus_i.read_data1 = '0; bus_i.read_data2 = '0; bus_i.ext_offset = '0;
    bus_i.alu_src = 1'b0; bus_i.alu_op = 3'b000; bus_i.funct = '0; bus_i.branch = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_res",  bus_i.alu_result, 32'h0);
    chk("rst_zf",   32'(bus_i.zf), 32'h0);
    chk("rst_pc4",  bus_i.pc_plus4, 32'h0);
    chk("rst_bt",   bus_i.branch_target, 32'h0);
    chk("rst_tb",   32'(bus_i.take_branch), 32'h0);
    chk("rst_ovf",  32'(bus_i.ovf), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // R-type add 5+7
    run(32'h0000_0040, 32'd5, 32'd7, 32'h0, 1'b0, 3'b010, 6'b100000, 1'b0, "radd", 4'b0010);
    chk("radd_res", bus_i.alu_result, 32'd12);
    chk("radd_zf",  32'(bus_i.zf), 32'h0);
    chk("radd_pc4", bus_i.pc_plus4, 32'h0000_0044);

    // beq taken, negative offset
    run(32'h0000_0100, 32'd9, 32'd9, 32'hFFFF_FFFE, 1'b0, 3'b001, 6'b000000, 1'b1, "beq", 4'b0110);
    chk("beq_zf",   32'(bus_i.zf), 32'h1);
    chk("beq_take", 32'(bus_i.take_branch), 32'h1);
    chk("beq_pc4",  bus_i.pc_plus4, 32'h0000_0104);
    chk("beq_bt",   bus_i.branch_target, 32'h0000_00FC);

    // beq not taken: nonzero difference; positive offset
    run(32'h0000_0200, 32'd9, 32'd4, 32'h0000_0010, 1'b0, 3'b001, 6'b000000, 1'b1, "bne", 4'b0110);
    chk("bne_res",  bus_i.alu_result, 32'd5);
    chk("bne_take", 32'(bus_i.take_branch), 32'h0);
    chk("bne_bt",   bus_i.branch_target, 32'h0000_0244);

    // slt immediate: -1 < 1
    run(32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0001, 1'b1, 3'b101, 6'b000000, 1'b0, "slt", 4'b0111);
    chk("slt_res", bus_i.alu_result, 32'd1);
    chk("slt_zf",  32'(bus_i.zf), 32'h0);

    // slt false: 1 < -1 is false
    run(32'h0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 3'b101, 6'b000000, 1'b0, "sltf", 4'b0111);
    chk("sltf_res", bus_i.alu_result, 32'd0);
    chk("sltf_zf",  32'(bus_i.zf), 32'h1);

    // Bad funct
    run(32'h0, 32'd5, 32'd7, 32'h0, 1'b0, 3'b010, 6'b000000, 1'b1, "badf", 4'b1111);
    chk("badf_res",  bus_i.alu_result, 32'h0);
    chk("badf_zf",   32'(bus_i.zf), 32'h1);
    chk("badf_take", 32'(bus_i.take_branch), 32'h1);

    // R-type funct set
    run(32'h0, 32'd10, 32'd3, 32'h0, 1'b0, 3'b010, 6'b100010, 1'b0, "rsub", 4'b0110);
    chk("rsub_res", bus_i.alu_result, 32'd7);
    run(32'h0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 1'b0, 3'b010, 6'b100100, 1'b0, "rand", 4'b0000);
    chk("rand_res", bus_i.alu_result, 32'h0000_F000);
    run(32'h0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 1'b0, 3'b010, 6'b100101, 1'b0, "ror", 4'b0001);
    chk("ror_res", bus_i.alu_result, 32'h0000_FFF0);
    run(32'h0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 1'b0, 3'b010, 6'b100110, 1'b0, "rxor", 4'b0011);
    chk("rxor_res", bus_i.alu_result, 32'h0000_0FF0);
    run(32'h0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 1'b0, 3'b010, 6'b100111, 1'b0, "rnor", 4'b1100);
    chk("rnor_res", bus_i.alu_result, 32'hFFFF_000F);
    run(32'h0, 32'd3, 32'd10, 32'h0, 1'b0, 3'b010, 6'b101010, 1'b0, "rslt", 4'b0111);
    chk("rslt_res", bus_i.alu_result, 32'd1);

    // Direct alu_op codes with immediate operand
    run(32'h0, 32'h1234_5678, 32'h0, 32'h0000_FFFF, 1'b1, 3'b011, 6'b0, 1'b0, "iand", 4'b0000);
    chk("iand_res", bus_i.alu_result, 32'h0000_5678);
    run(32'h0, 32'h1234_0000, 32'h0, 32'h0000_00FF, 1'b1, 3'b100, 6'b0, 1'b0, "ior", 4'b0001);
    chk("ior_res", bus_i.alu_result, 32'h1234_00FF);
    run(32'h0, 32'hFFFF_0000, 32'h0, 32'hFFFF_FFFF, 1'b1, 3'b110, 6'b0, 1'b0, "ixor", 4'b0011);
    chk("ixor_res", bus_i.alu_result, 32'h0000_FFFF);
    run(32'h0, 32'hFFFF_0000, 32'h0, 32'h0000_FFFF, 1'b1, 3'b111, 6'b0, 1'b0, "inor", 4'b1100);
    chk("inor_res", bus_i.alu_result, 32'h0);
    chk("inor_zf",  32'(bus_i.zf), 32'h1);

    // PC wrap
    run(32'hFFFF_FFFC, 32'd1, 32'd1, 32'h0000_0001, 1'b0, 3'b000, 6'b0, 1'b0, "wrap", 4'b0010);
    chk("wrap_pc4", bus_i.pc_plus4, 32'h0);
    chk("wrap_bt",  bus_i.branch_target, 32'h0000_0004);
    chk("wrap_res", bus_i.alu_result, 32'd2);
    chk("wrap_ovf", 32'(bus_i.ovf), 32'h0);

    // ADD overflow
    run(32'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 3'b000, 6'b0, 1'b0, "aovf", 4'b0010);
    chk("aovf_res", bus_i.alu_result, 32'h8000_0000);
    chk("aovf_ovf", 32'(bus_i.ovf), 32'(OVF_ON));

    // SUB overflow: min - 1
    run(32'h0, 32'h8000_0000, 32'h0000_0001, 32'h0, 1'b0, 3'b001, 6'b0, 1'b0, "sovf", 4'b0110);
    chk("sovf_res", bus_i.alu_result, 32'h7FFF_FFFF);
    chk("sovf_ovf", 32'(bus_i.ovf), 32'(OVF_ON));

    // Overflow-looking operands on a logical op must not flag
    run(32'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 3'b100, 6'b0, 1'b0, "lovf", 4'b0001);
    chk("lovf_ovf", 32'(bus_i.ovf), 32'h0);

    // Load nonzero state, then async reset between edges
    run(32'h0000_1000, 32'd20, 32'd20, 32'h0000_0008, 1'b0, 3'b001, 6'b0, 1'b1, "pre", 4'b0110);
    chk("pre_take", 32'(bus_i.take_branch), 32'h1);
    chk("pre_pc4",  bus_i.pc_plus4, 32'h0000_1004);
    #2 rst = 1'b1;
    #1;
    chk("arst_res",  bus_i.alu_result, 32'h0);
    chk("arst_zf",   32'(bus_i.zf), 32'h0);
    chk("arst_pc4",  bus_i.pc_plus4, 32'h0);
    chk("arst_bt",   bus_i.branch_target, 32'h0);
    chk("arst_take", 32'(bus_i.take_branch), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // First edge after reset release updates registers
    run(32'h0000_0008, 32'd1, 32'd2, 32'h0, 1'b0, 3'b000, 6'b0, 1'b0, "post", 4'b0010);
    chk("post_res", bus_i.alu_result, 32'd3);
    chk("post_pc4", bus_i.pc_plus4, 32'h0000_000C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
